// File: rtl/detector_feed_ctrl.sv
// rtl/detector_feed_ctrl.sv - round-robin nibble feeder for the serial pattern detector
// Serialises granted nibbles MSB-first, tracks the last four fed bits and counts detector hits.
module detector_feed_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_req,
  input  logic [3:0]         a_data,
  output logic               a_ack,
  input  logic               b_req,
  input  logic [3:0]         b_data,
  output logic               b_ack,
  input  logic               clr,
  output logic               det_bit,
  output logic               det_step,
  input  logic               det_hit,
  output logic [3:0]         hist,
  output logic [COUNT_W-1:0] hit_count,
  output logic               hit_pulse,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         shreg_q, shreg_d;
  logic               last_grant_q, last_grant_d;  // 1 = B was granted last
  logic [3:0]         hist_q, hist_d;
  logic [COUNT_W-1:0] hit_count_q, hit_count_d;
  logic               step_d_q, step_d_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd3;
      shreg_q      <= 4'd0;
      last_grant_q <= 1'b1;
      hist_q       <= 4'd0;
      hit_count_q  <= '0;
      step_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      last_grant_q <= last_grant_d;
      hist_q       <= hist_d;
      hit_count_q  <= hit_count_d;
      step_d_q     <= step_d_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    last_grant_d = last_grant_q;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    det_bit      = 1'b0;
    det_step     = 1'b0;

    case (state_q)
      IDLE: begin
        // Acks are combinational, so they must stay quiet while reset is held.
        if (!reset) begin
          if (a_req && (!b_req || last_grant_q)) begin
            a_ack        = 1'b1;
            shreg_d      = a_data;
            last_grant_d = 1'b0;
            idx_d        = 2'd3;
            state_d      = SHIFT;
          end else if (b_req) begin
            b_ack        = 1'b1;
            shreg_d      = b_data;
            last_grant_d = 1'b1;
            idx_d        = 2'd3;
            state_d      = SHIFT;
          end
        end
      end
      SHIFT: begin
        det_step = 1'b1;
        det_bit  = shreg_q[idx_q];
        if (idx_q == 2'd0) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    hit_pulse = step_d_q & det_hit;
    step_d_d  = det_step;

    hist_d = hist_q;
    if (clr) begin
      hist_d = 4'd0;
    end else if (det_step) begin
      hist_d = {hist_q[2:0], det_bit};
    end

    hit_count_d = hit_count_q;
    if (clr) begin
      hit_count_d = '0;
    end else if (hit_pulse && (hit_count_q != CNT_MAX)) begin
      hit_count_d = hit_count_q + 1'b1;
    end
  end

  assign hist      = hist_q;
  assign hit_count = hit_count_q;
  assign busy      = (state_q != IDLE);

endmodule
